// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download controller.
// Holds the controller state encoding and the default core-reset hold length.
// No logic lives here.
package rom_dl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } dl_state_t;

    localparam int DEF_HOLD_CYC = 255;
    localparam int HOLD_W       = $clog2(DEF_HOLD_CYC + 1);

endpackage

// File: rtl/rom_dl_ctrl.sv
// Purpose: filter the ioctl download for the game ROM slot, forward writes to the
//          core and sequence core_reset around a validated image.
// Latency: dn_* follows an accepted ioctl_wr by exactly 1 cycle; no backpressure
//          (ioctl is a fire-and-forget byte stream, every accepted byte is forwarded).
// Ports:   clk_sys/reset (sync, active high); ioctl_* download stream in;
//          user_reset (OSD/button); dn_addr/dn_data/dn_wr core ROM port out;
//          core_reset, rom_valid, size_err, byte_count status out.
module rom_dl_ctrl
    import rom_dl_pkg::*;
#(
    parameter logic [7:0] ROM_INDEX = 8'd0,
    parameter int         ADDR_W    = 14,
    parameter int         EXP_BYTES = 16384,
    parameter int         HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              user_reset,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic              dn_wr,
    output logic              core_reset,
    output logic              rom_valid,
    output logic              size_err,
    output logic [ADDR_W:0]   byte_count
);

    localparam int              HW       = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0]   HOLD_LD  = HOLD_CYC[HW-1:0];
    localparam logic [HW-1:0]   HOLD_ONE = 1;
    localparam logic [ADDR_W:0] EXP_CNT  = EXP_BYTES[ADDR_W:0];
    localparam logic [ADDR_W:0] CNT_ONE  = 1;

    dl_state_t         state_q, state_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [ADDR_W:0]   byte_count_q, byte_count_d, cnt_base;
    logic              nz_q, nz_d, nz_base;
    logic              oor_q, oor_d, oor_base;
    logic              rom_valid_q, rom_valid_d;
    logic              size_err_q, size_err_d;
    logic [ADDR_W-1:0] dn_addr_q, dn_addr_d;
    logic [7:0]        dn_data_q, dn_data_d;
    logic              dn_wr_q, dn_wr_d;
    logic              act_q, act_d;

    logic act, start, stop, in_range, window, acc, oor_hit;

    assign act      = ioctl_download && (ioctl_index == ROM_INDEX);
    assign start    = act && !act_q;
    assign stop     = !act && act_q;
    assign in_range = (ioctl_addr[24:ADDR_W] == '0);
    // Writes count only inside a download we actually started: the Start cycle
    // itself, or any cycle in LOAD (which includes the End cycle). A download
    // interrupted by reset stays unforwarded because act_q keeps tracking act
    // through reset, so no fresh Start is seen.
    assign window   = start || (state_q == LOAD);
    assign acc      = window && ioctl_wr && in_range;
    assign oor_hit  = window && ioctl_wr && !in_range;

    always_comb begin
        act_d = act;

        // Start clears the image bookkeeping before the same-cycle write lands.
        cnt_base = start ? '0   : byte_count_q;
        nz_base  = start ? 1'b0 : nz_q;
        oor_base = start ? 1'b0 : oor_q;

        byte_count_d = byte_count_q;
        nz_d         = nz_q;
        oor_d        = oor_q;
        if (window) begin
            byte_count_d = (acc && (cnt_base != '1)) ? cnt_base + CNT_ONE : cnt_base;
            nz_d         = nz_base || (acc && (ioctl_dout != 8'd0));
            oor_d        = oor_base || oor_hit;
        end

        dn_wr_d   = acc;
        dn_addr_d = acc ? ioctl_addr[ADDR_W-1:0] : dn_addr_q;
        dn_data_d = acc ? ioctl_dout : dn_data_q;

        state_d     = state_q;
        hold_d      = hold_q;
        rom_valid_d = rom_valid_q;
        size_err_d  = size_err_q;

        case (state_q)
            LOAD: begin
                if (stop) begin
                    // byte_count_d/nz_d/oor_d already include an End-cycle write.
                    size_err_d = (byte_count_d != EXP_CNT) || oor_d;
                    if (nz_d) begin
                        rom_valid_d = 1'b1;
                        hold_d      = HOLD_LD;
                        state_d     = HOLD;
                    end else begin
                        rom_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            HOLD: begin
                if (user_reset) begin
                    hold_d = HOLD_LD;
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                    if (hold_q == HOLD_ONE) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (user_reset) begin
                    hold_d  = HOLD_LD;
                    state_d = HOLD;
                end
            end
            default: begin
            end
        endcase

        // A new download outranks the user reset and any hold in progress.
        if (start) begin
            state_d = LOAD;
        end
    end

    always_ff @(posedge clk_sys) begin
        act_q <= act_d;
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            byte_count_q <= '0;
            nz_q         <= 1'b0;
            oor_q        <= 1'b0;
            rom_valid_q  <= 1'b0;
            size_err_q   <= 1'b0;
            dn_addr_q    <= '0;
            dn_data_q    <= 8'd0;
            dn_wr_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            byte_count_q <= byte_count_d;
            nz_q         <= nz_d;
            oor_q        <= oor_d;
            rom_valid_q  <= rom_valid_d;
            size_err_q   <= size_err_d;
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
            dn_wr_q      <= dn_wr_d;
        end
    end

    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dn_wr      = dn_wr_q;
    assign core_reset = (state_q != RUN);
    assign rom_valid  = rom_valid_q;
    assign size_err   = size_err_q;
    assign byte_count = byte_count_q;

endmodule
